// File: rtl/updown_pkg.sv
// Shared encodings for the up/down sweep controller and its 4-bit counter.
// State codes, direction constants and the start-request bounds check.
package updown_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // A run is legal only with a non-empty range and at least one sweep.
    function automatic logic bounds_ok(input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi,
                                       input logic [CNT_W-1:0] sw);
        return (lo < hi) && (sw != '0);
    endfunction

endpackage

// File: rtl/updown_counter.sv
// 4-bit up/down counter with active-low synchronous load (LTn) and output-valid (oe).
// oe is low while in reset and rises on the first clock edge afterwards.
module updown_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       LTn,
    input  logic       Upn_down,
    input  logic [3:0] Load,
    output logic [3:0] dout,
    output logic       oe
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= 4'd0;
            oe   <= 1'b0;
        end else begin
            oe <= 1'b1;
            if (!LTn)
                dout <= Load;
            else if (Upn_down)
                dout <= dout - 4'd1;
            else
                dout <= dout + 4'd1;
        end
    end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Drives a 4-bit up/down counter through repeated lo->hi->lo triangle sweeps.
// Commands are combinational from state and counter readback; done/err/busy are registered.
module updown_sweep_ctrl
    import updown_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_arst,
    input  logic       i_start,
    input  logic [3:0] i_lo,
    input  logic [3:0] i_hi,
    input  logic [3:0] i_sweeps,
    input  logic [3:0] i_cnt_q,
    input  logic       i_cnt_valid,
    output logic       o_ltn,
    output logic       o_upn_down,
    output logic [3:0] o_load,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    output logic [3:0] o_sweep_cnt
);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_lo;
    logic [3:0] r_hi;
    logic [3:0] r_sw;
    logic [3:0] r_sweep_cnt;
    logic       r_busy;
    logic       r_done;
    logic       r_err;

    logic [3:0] w_sweep_inc;
    logic       w_accept;
    logic       w_reject;
    logic       w_abort;
    logic       w_lap;
    logic       w_finish;

    always_comb begin
        w_next      = r_state;
        o_ltn       = 1'b1;
        o_upn_down  = DIR_UP;
        o_load      = r_lo;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_abort     = 1'b0;
        w_lap       = 1'b0;
        w_finish    = 1'b0;
        w_sweep_inc = r_sweep_cnt + 4'd1;

        case (r_state)
            ST_IDLE: begin
                // Keep loading lo so the counter sits at the sweep origin.
                o_ltn  = 1'b0;
                o_load = i_lo;
                if (i_start) begin
                    if (!bounds_ok(i_lo, i_hi, i_sweeps)) begin
                        w_reject = 1'b1;
                    end else if (i_cnt_valid && (i_cnt_q == i_lo)) begin
                        w_accept = 1'b1;
                        w_next   = ST_UP;
                    end
                end
            end
            ST_UP: begin
                if (!i_cnt_valid) begin
                    w_abort = 1'b1;
                    w_next  = ST_IDLE;
                end else if (i_cnt_q == r_hi) begin
                    o_upn_down = DIR_DOWN;
                    w_next     = ST_DOWN;
                end
            end
            ST_DOWN: begin
                o_upn_down = DIR_DOWN;
                if (!i_cnt_valid) begin
                    w_abort = 1'b1;
                    w_next  = ST_IDLE;
                end else if (i_cnt_q == r_lo) begin
                    w_lap      = 1'b1;
                    o_upn_down = DIR_UP;
                    if (w_sweep_inc == r_sw) begin
                        w_finish = 1'b1;
                        o_ltn    = 1'b0;
                        o_load   = r_lo;
                        w_next   = ST_IDLE;
                    end else begin
                        w_next = ST_UP;
                    end
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_state     <= ST_IDLE;
            r_lo        <= 4'd0;
            r_hi        <= 4'd0;
            r_sw        <= 4'd0;
            r_sweep_cnt <= 4'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            // busy covers the run minus its first cycle: high for sweeps*2*(hi-lo) cycles.
            r_busy  <= (r_state != ST_IDLE) && (w_next != ST_IDLE);
            r_done  <= w_finish;
            r_err   <= w_reject | w_abort;
            if (w_accept) begin
                r_lo        <= i_lo;
                r_hi        <= i_hi;
                r_sw        <= i_sweeps;
                r_sweep_cnt <= 4'd0;
            end else if (w_lap) begin
                r_sweep_cnt <= w_sweep_inc;
            end
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_sweep_cnt = r_sweep_cnt;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl driving the team up/down counter in closed loop.
module tb_updown_sweep_ctrl;

    logic       clk      = 1'b0;
    logic       arst     = 1'b0;
    logic       start    = 1'b0;
    logic       cnt_kill = 1'b0;
    logic [3:0] lo       = 4'd0;
    logic [3:0] hi       = 4'd0;
    logic [3:0] sweeps   = 4'd0;

    logic [3:0] cnt_q;
    logic       cnt_valid;
    logic       ltn;
    logic       upn_down;
    logic [3:0] load;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] sweep_cnt;

    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    updown_sweep_ctrl dut (
        .i_clk       (clk),
        .i_arst      (arst),
        .i_start     (start),
        .i_lo        (lo),
        .i_hi        (hi),
        .i_sweeps    (sweeps),
        .i_cnt_q     (cnt_q),
        .i_cnt_valid (cnt_valid),
        .o_ltn       (ltn),
        .o_upn_down  (upn_down),
        .o_load      (load),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err),
        .o_sweep_cnt (sweep_cnt)
    );

    updown_counter u_cnt (
        .clk      (clk),
        .rst_n    (~arst & ~cnt_kill),
        .LTn      (ltn),
        .Upn_down (upn_down),
        .Load     (load),
        .dout     (cnt_q),
        .oe       (cnt_valid)
    );

    task automatic test_reset();
        #1 arst = 1'b1;
        lo = 4'd9;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (sweep_cnt !== 4'd0) begin failures++; $display("FAIL reset_sweep_cnt got=%0d exp=0", sweep_cnt); end
        checks++; if (ltn !== 1'b0) begin failures++; $display("FAIL reset_ltn got=%b exp=0", ltn); end
        checks++; if (upn_down !== 1'b0) begin failures++; $display("FAIL reset_upn_down got=%b exp=0", upn_down); end
        checks++; if (load !== 4'd9) begin failures++; $display("FAIL reset_load got=%0d exp=9", load); end
        lo = 4'd5;
        #1;
        checks++; if (load !== 4'd5) begin failures++; $display("FAIL reset_load_follow got=%0d exp=5", load); end
        @(negedge clk);
        arst = 1'b0;
    endtask

    // Runs one full sweep program and scoreboards every counter value.
    task automatic test_sweep_run(input logic [3:0] t_lo, input logic [3:0] t_hi,
                                  input logic [3:0] t_sw, input string name);
        int   run_len;
        int   busy_cycles;
        int   done_cycles;
        int   done_at;
        bit   got;
        logic [3:0] exp;
        run_len = int'(t_sw) * 2 * (int'(t_hi) - int'(t_lo));
        @(negedge clk);
        lo = t_lo; hi = t_hi; sweeps = t_sw; start = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ltn === 1'b1) got = 1'b1;
        end
        start = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s_accept got=no_accept exp=accept_within_20", name);
            return;
        end
        exp_q.delete();
        for (int s = 0; s < int'(t_sw); s++) begin
            for (int v = int'(t_lo); v < int'(t_hi); v++) exp_q.push_back(4'(v));
            for (int v = int'(t_hi); v > int'(t_lo); v--) exp_q.push_back(4'(v));
        end
        for (int j = 0; j < 4; j++) exp_q.push_back(t_lo);
        busy_cycles = 0; done_cycles = 0; done_at = -1;
        for (int k = 0; k < run_len + 4; k++) begin
            if (k > 0) @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (cnt_q !== exp) begin
                failures++;
                $display("FAIL %s_cnt_q[%0d] got=%0d exp=%0d", name, k, cnt_q, exp);
            end
            if (busy === 1'b1) busy_cycles++;
            if (done === 1'b1) begin done_cycles++; done_at = k; end
        end
        checks++; if (busy_cycles !== run_len) begin failures++; $display("FAIL %s_busy_len got=%0d exp=%0d", name, busy_cycles, run_len); end
        checks++; if (done_cycles !== 1) begin failures++; $display("FAIL %s_done_count got=%0d exp=1", name, done_cycles); end
        checks++; if (done_at !== run_len + 1) begin failures++; $display("FAIL %s_done_at got=%0d exp=%0d", name, done_at, run_len + 1); end
        checks++; if (sweep_cnt !== t_sw) begin failures++; $display("FAIL %s_sweep_cnt got=%0d exp=%0d", name, sweep_cnt, t_sw); end
    endtask

    task automatic test_reject();
        logic [3:0] cases_lo[2] = '{4'd7, 4'd2};
        logic [3:0] cases_hi[2] = '{4'd7, 4'd9};
        logic [3:0] cases_sw[2] = '{4'd2, 4'd0};
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            lo = cases_lo[c]; hi = cases_hi[c]; sweeps = cases_sw[c]; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checks++; if (err !== 1'b1) begin failures++; $display("FAIL reject%0d_err got=%b exp=1", c, err); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reject%0d_busy got=%b exp=0", c, busy); end
            checks++; if (ltn !== 1'b0) begin failures++; $display("FAIL reject%0d_ltn got=%b exp=0", c, ltn); end
            checks++; if (cnt_q !== cases_lo[c]) begin failures++; $display("FAIL reject%0d_cnt_q got=%0d exp=%0d", c, cnt_q, cases_lo[c]); end
            @(negedge clk);
            checks++; if (err !== 1'b0) begin failures++; $display("FAIL reject%0d_err_pulse got=%b exp=0", c, err); end
            checks++; if (cnt_q !== cases_lo[c]) begin failures++; $display("FAIL reject%0d_held got=%0d exp=%0d", c, cnt_q, cases_lo[c]); end
        end
    endtask

    task automatic test_counter_abort();
        bit got;
        @(negedge clk);
        lo = 4'd2; hi = 4'd6; sweeps = 4'd3; start = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ltn === 1'b1) got = 1'b1;
        end
        start = 1'b0;
        for (int i = 0; i < 40 && got; i++) begin
            if (sweep_cnt === 4'd1 && upn_down === 1'b1 && cnt_q === 4'd4) break;
            @(negedge clk);
            if (i == 39) got = 1'b0;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL abort_reach_down got=not_reached exp=down_in_sweep2");
            return;
        end
        cnt_kill = 1'b1;
        #1;
        checks++; if (cnt_valid !== 1'b0) begin failures++; $display("FAIL abort_oe got=%b exp=0", cnt_valid); end
        @(negedge clk);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL abort_err got=%b exp=1", err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (ltn !== 1'b0) begin failures++; $display("FAIL abort_ltn got=%b exp=0", ltn); end
        checks++; if (sweep_cnt !== 4'd1) begin failures++; $display("FAIL abort_sweep_cnt got=%0d exp=1", sweep_cnt); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", done); end
        cnt_kill = 1'b0;
        @(negedge clk);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL abort_err_pulse got=%b exp=0", err); end
        checks++; if (sweep_cnt !== 4'd1) begin failures++; $display("FAIL abort_sweep_keep got=%0d exp=1", sweep_cnt); end
    endtask

    task automatic test_arst_mid_run();
        bit got;
        int pulses;
        @(negedge clk);
        lo = 4'd3; hi = 4'd8; sweeps = 4'd1; start = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ltn === 1'b1) got = 1'b1;
        end
        start = 1'b0;
        if (got) @(negedge clk);
        checks++; if (!got || cnt_q !== 4'd4) begin failures++; $display("FAIL arst_setup_cnt_q got=%0d exp=4", cnt_q); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL arst_setup_busy got=%b exp=1", busy); end
        #2 arst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", busy); end
        checks++; if (ltn !== 1'b0) begin failures++; $display("FAIL arst_ltn got=%b exp=0", ltn); end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || err !== 1'b0) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL arst_no_pulse got=%0d exp=0", pulses); end
        checks++; if (sweep_cnt !== 4'd0) begin failures++; $display("FAIL arst_sweep_cnt got=%0d exp=0", sweep_cnt); end
        arst = 1'b0;
        test_sweep_run(4'd3, 4'd5, 4'd1, "post_arst");
    endtask

    task automatic test_start_before_valid();
        bit got;
        @(negedge clk);
        arst = 1'b1;
        @(negedge clk);
        lo = 4'd4; hi = 4'd6; sweeps = 4'd1;
        arst = 1'b0; start = 1'b1;
        #1;
        checks++; if (cnt_valid !== 1'b0) begin failures++; $display("FAIL sbv_oe_low got=%b exp=0", cnt_valid); end
        @(negedge clk);
        start = 1'b0;
        checks++; if (ltn !== 1'b0) begin failures++; $display("FAIL sbv_pulse_ignored got=%b exp=0", ltn); end
        @(negedge clk);
        checks++; if (ltn !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL sbv_still_idle got=%b%b exp=00", ltn, busy); end
        arst = 1'b1;
        @(negedge clk);
        arst = 1'b0; start = 1'b1;
        @(negedge clk);
        checks++; if (ltn !== 1'b0) begin failures++; $display("FAIL sbv_held_wait got=%b exp=0", ltn); end
        checks++; if (cnt_valid !== 1'b1 || cnt_q !== 4'd4) begin failures++; $display("FAIL sbv_counter_settled got=%b/%0d exp=1/4", cnt_valid, cnt_q); end
        @(negedge clk);
        start = 1'b0;
        checks++; if (ltn !== 1'b1 || cnt_q !== 4'd4) begin failures++; $display("FAIL sbv_accept got=%b/%0d exp=1/4", ltn, cnt_q); end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (done === 1'b1) got = 1'b1;
        end
        checks++; if (!got) begin failures++; $display("FAIL sbv_done got=none exp=pulse"); end
        checks++; if (sweep_cnt !== 4'd1) begin failures++; $display("FAIL sbv_sweep_cnt got=%0d exp=1", sweep_cnt); end
    endtask

    initial begin
        test_reset();
        test_sweep_run(4'd3, 4'd5, 4'd2, "double_sweep");
        test_sweep_run(4'd0, 4'd15, 4'd1, "full_range");
        test_reject();
        test_counter_abort();
        test_arst_mid_run();
        test_start_before_valid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
